// File: rtl/inst_fifo.sv
// inst_fifo -- instruction buffer between the slave write path and the GPU
// main controller. First-word-fall-through: the head word and its type bit
// are presented before the pop, so the controller can branch in the same
// cycle it pulses read_en.
//
// Ports:
//   clk         system clock, rising edge
//   n_rst       asynchronous active-low reset
//   clear       synchronous flush (overrides write/read that cycle)
//   write_en    push write_data
//   write_data  instruction word from the slave
//   read_en     pop the head entry
//   read_data   head entry, 0 when empty
//   inst_type   MSB of head entry (0 = shape, 1 = alpha), 0 when empty
//   fifo_empty  count == 0
//   fifo_full   count == DEPTH
//   count       occupancy 0..DEPTH
//   overflow    sticky: a write was dropped
//   underflow   sticky: a read was ignored
module inst_fifo #(
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int ADDR_BITS  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  clear,
    input  logic                  write_en,
    input  logic [INST_WIDTH-1:0] write_data,
    input  logic                  read_en,
    output logic [INST_WIDTH-1:0] read_data,
    output logic                  inst_type,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic [ADDR_BITS:0]    count,
    output logic                  overflow,
    output logic                  underflow
);

    logic [INST_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_BITS-1:0]  wr_ptr;
    logic [ADDR_BITS-1:0]  rd_ptr;

    logic do_write;
    logic do_read;
    logic set_overflow;
    logic set_underflow;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (ADDR_BITS+1)'(DEPTH));

    assign read_data = fifo_empty ? '0 : mem[rd_ptr];
    assign inst_type = read_data[INST_WIDTH-1];

    // A full FIFO still accepts a write when the head is popped in the same
    // cycle: the freed slot takes the new word, so no overflow is raised.
    // An empty FIFO with both strobes only pushes; the new word is not
    // bypassed to the output.
    always_comb begin
        do_write      = 1'b0;
        do_read       = 1'b0;
        set_overflow  = 1'b0;
        set_underflow = 1'b0;
        if (!clear) begin
            do_read       = read_en && !fifo_empty;
            do_write      = write_en && (!fifo_full || read_en);
            set_overflow  = write_en && !read_en && fifo_full;
            set_underflow = read_en && fifo_empty;
        end
    end

    // Storage needs no reset; its contents are irrelevant while count is 0.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= write_data;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + ADDR_BITS'(1);
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + ADDR_BITS'(1);
            end
            case ({do_write, do_read})
                2'b10:   count <= count + (ADDR_BITS+1)'(1);
                2'b01:   count <= count - (ADDR_BITS+1)'(1);
                default: count <= count;
            endcase
            if (set_overflow) begin
                overflow <= 1'b1;
            end
            if (set_underflow) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule
